jpeg_bitstream_packer: RTL and testbench

- Sits directly downstream of the Huffman encode controller in the JPEG HW encoder.
- Accepts variable-length Huffman/amplitude codes of 0..16 bits and packs them MSB-first into a continuous byte stream.
- Inserts the JPEG 0x00 stuffing byte after every emitted 0xFF.
- On flush, pads the final partial byte with 1s, so that entropy-coded segment ends are byte-aligned before the marker writer.

---
 rtl/jpeg_bitstream_packer.sv | 164 ++++++++++++++++
 tb/tb_jpeg_bitstream_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : jpeg_bitstream_packer
//  Description : Packs 0..16-bit Huffman/amplitude codes MSB-first into a byte
//                stream. Inserts a 0x00 stuffing byte after every 0xFF. On
//                flush, pads the last partial byte with 1s and drains.
//                Optional output byte counter: JPEG_PACKER_BYTECOUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_bitstream_packer #(
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_code,
  input  logic [4:0]  in_length,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        flush_done,
  output logic        busy
`ifdef JPEG_PACKER_BYTECOUNT_EN
  ,
  output logic [31:0] byte_count
`endif
);

  localparam int c_cnt_w = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAD   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic               r_stuff_pending;
  logic               r_out_valid;
  logic [7:0]         r_out_byte;
  logic               r_flush_done;

  logic [4:0]         w_len;
  logic [ACC_W-1:0]   w_code_bits;
  logic [3:0]         w_pad_len;
  logic [ACC_W-1:0]   w_pad_bits;
  logic               w_accept;
  logic [4:0]         w_add_len;
  logic [ACC_W-1:0]   w_add_bits;
  logic               w_out_free;
  logic               w_load_stuff;
  logic               w_load_data;
  logic [7:0]         w_top_byte;
  logic [c_cnt_w-1:0] w_bit_cnt_next;
  logic               w_drain_done;

  // Over-long lengths are clamped; bits at and above the length are ignored.
  assign w_len       = (in_length > 5'(MAX_LEN)) ? 5'(MAX_LEN) : in_length;
  assign w_code_bits = ACC_W'(in_code) & ((ACC_W'(1) << w_len) - ACC_W'(1));

  // Padding rounds the valid bit count up to the next byte boundary with 1s.
  assign w_pad_len  = (r_bit_cnt[2:0] == 3'd0) ? 4'd0 : (4'd8 - {1'b0, r_bit_cnt[2:0]});
  assign w_pad_bits = (ACC_W'(1) << w_pad_len) - ACC_W'(1);

  // Reset is folded in so in_ready stays low for as long as reset is held.
  assign in_ready = (r_state == ST_RUN) && (r_bit_cnt <= c_cnt_w'(ACC_W - MAX_LEN)) && !reset;
  assign w_accept = in_valid && in_ready;

  // Select what gets appended below the current bits this cycle.
  always_comb begin
    w_add_len  = 5'd0;
    w_add_bits = '0;
    if (w_accept) begin
      w_add_len  = w_len;
      w_add_bits = w_code_bits;
    end else if (r_state == ST_PAD) begin
      w_add_len  = {1'b0, w_pad_len};
      w_add_bits = w_pad_bits;
    end
  end

  // The output register may reload when empty or when its byte leaves now.
  assign w_out_free   = !r_out_valid || out_ready;
  assign w_load_stuff = w_out_free && r_stuff_pending;
  assign w_load_data  = w_out_free && !r_stuff_pending && (r_bit_cnt >= c_cnt_w'(8));
  // Valid bits sit right-aligned in r_acc; the oldest byte is the top eight.
  assign w_top_byte   = 8'(r_acc >> (r_bit_cnt - c_cnt_w'(8)));

  assign w_bit_cnt_next = r_bit_cnt + c_cnt_w'(w_add_len)
                          - (w_load_data ? c_cnt_w'(8) : c_cnt_w'(0));

  assign w_drain_done = (r_state == ST_DRAIN) && (r_bit_cnt == '0) &&
                        !r_stuff_pending && w_out_free;

  // Flush sequencing: RUN -> PAD (one cycle) -> DRAIN until empty -> RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (flush) w_state_next = ST_PAD;
      ST_PAD:   w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // Bit accumulator, one-byte output register and stuffing/flush flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc           <= '0;
      r_bit_cnt       <= '0;
      r_stuff_pending <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_byte      <= 8'h00;
      r_flush_done    <= 1'b0;
    end else begin
      r_acc        <= (r_acc << w_add_len) | w_add_bits;
      r_bit_cnt    <= w_bit_cnt_next;
      r_flush_done <= w_drain_done;
      if (w_load_stuff) begin
        r_out_valid     <= 1'b1;
        r_out_byte      <= 8'h00;
        r_stuff_pending <= 1'b0;
      end else if (w_load_data) begin
        r_out_valid     <= 1'b1;
        r_out_byte      <= w_top_byte;
        r_stuff_pending <= (w_top_byte == 8'hFF);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_byte   = r_out_byte;
  assign flush_done = r_flush_done;
  assign busy       = (r_state != ST_RUN);

`ifdef JPEG_PACKER_BYTECOUNT_EN
  logic [31:0] r_byte_count;

  // Count output handshakes, frozen during the flush_done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                         r_byte_count <= 32'd0;
    else if (r_out_valid && out_ready && !r_flush_done) r_byte_count <= r_byte_count + 32'd1;
  end

  assign byte_count = r_byte_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jpeg_bitstream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_bitstream_packer
//  Description : Scoreboard bench for jpeg_bitstream_packer. Stimulus pushes
//                expected bytes / flush_done events; a monitor pops them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_bitstream_packer;

  localparam int EV_DONE = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_code = 16'h0;
  logic [4:0]  in_length = 5'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        flush_done;
  logic        busy;
`ifdef JPEG_PACKER_BYTECOUNT_EN
  logic [31:0] byte_count;
`endif

  jpeg_bitstream_packer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_length  (in_length),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .flush_done (flush_done),
    .busy       (busy)
`ifdef JPEG_PACKER_BYTECOUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int bytes_since_reset = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on each output handshake / flush_done, and
  // checks that a stalled byte stays valid and unchanged.
  logic       held = 1'b0;
  logic [7:0] held_byte = 8'h00;
  always @(negedge clock) begin
    if (reset) begin
      held = 1'b0;
      bytes_since_reset = 0;
    end else begin
      if (held) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_byte", {24'd0, out_byte}, {24'd0, held_byte});
      end
      held      = out_valid && !out_ready;
      held_byte = out_byte;
      if (out_valid && out_ready) begin
        bytes_since_reset++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL stray_byte: got %0h expected none at %0t", out_byte, $time);
        end else begin
          check("out_byte", {24'd0, out_byte}, exp_q.pop_front());
        end
      end
      if (flush_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL stray_flush_done: got pulse expected none at %0t", $time);
        end else begin
          check("flush_done_order", EV_DONE, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] code, input logic [4:0] len);
    in_valid  = 1'b1;
    in_code   = code;
    in_length = len;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    check("send_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_byte", {24'd0, out_byte}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1 check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic packing with latency: 101 + 11111 -> 0xBF (upper code bits ignored).
    out_ready = 1'b1;
    exp_q.push_back(8'hBF);
    send(16'hFFF5, 5'd3);
    send(16'h001F, 5'd5);
    @(negedge clock);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_byte", {24'd0, out_byte}, 32'hBF);
    wait_idle();

    // Stuffing and length clamp.
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send(16'h00FF, 5'd8);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send(16'hFFFF, 5'd16);
    exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
    send(16'hABCD, 5'd20);
    wait_idle();

    // Flush pad: 0 + 1111111 -> 0x7F.
    exp_q.push_back(8'h7F); exp_q.push_back(EV_DONE);
    send(16'h0000, 5'd1);
    do_flush();
    check("flush_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Flush pad producing 0xFF, which must be stuffed.
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(EV_DONE);
    send(16'h000F, 5'd4);
    do_flush();
    wait_idle();

    // Backpressure.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) send(16'h1234, 5'd16);
      end
      begin
        repeat (8) @(negedge clock);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_out_byte", {24'd0, out_byte}, 32'h12);
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();

    // Flush together with a beat: 110 + 11111 -> 0xDF.
    exp_q.push_back(8'hDF); exp_q.push_back(EV_DONE);
    in_valid = 1'b1; in_code = 16'h0006; in_length = 5'd3; flush = 1'b1;
    check("sim_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("sim_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset mid-stream with a stuff byte pending.
    out_ready = 1'b0;
    send(16'h00FF, 5'd8);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    check("pre_rst_byte", {24'd0, out_byte}, 32'hFF);
    #2 reset = 1'b1;
    #1 check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(EV_DONE);
    do_flush();
    wait_idle();
    repeat (10) tick();

`ifdef JPEG_PACKER_BYTECOUNT_EN
    check("byte_count", byte_count, bytes_since_reset);
`endif
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
